fft_frame_loader: RTL and testbench

Upstream feeder for the 8-point FFT core. Accepts a serial stream of complex samples over a valid/ready handshake and assembles 8 consecutive samples into a parallel frame. It then drives the core's `write` and `start` strobes in sequence and reports completion. Sample words pass through unmodified: the loader does no format conversion or arithmetic on data.

---
 rtl/fft_frame_loader.sv | 184 ++++++++++++++++++
 tb/tb_fft_frame_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader.sv
// fft_frame_loader
// Collects 8 serial complex samples from a valid/ready stream into parallel
// frame slots. When a frame is complete it pulses the FFT core's write
// strobe, holds start for START_CYCLES cycles, and then pulses frame_done.
// Sample words are passed through untouched.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   s_valid/s_ready           upstream handshake
//   s_real/s_imag/s_last      sample words, s_last marks the 8th sample
//   outK_real/outK_imag       frame slot K (K = 0..7), to the FFT inputs
//   write, start              FFT load and compute strobes
//   frame_done, frame_err     one-cycle status pulses
//   frames_issued             wrapping count of write strobes
module fft_frame_loader #(
   parameter int WIDTH        = 16,
   parameter int START_CYCLES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_real,
   input  logic [WIDTH-1:0] s_imag,
   input  logic             s_last,
   output logic [WIDTH-1:0] out0_real,
   output logic [WIDTH-1:0] out1_real,
   output logic [WIDTH-1:0] out2_real,
   output logic [WIDTH-1:0] out3_real,
   output logic [WIDTH-1:0] out4_real,
   output logic [WIDTH-1:0] out5_real,
   output logic [WIDTH-1:0] out6_real,
   output logic [WIDTH-1:0] out7_real,
   output logic [WIDTH-1:0] out0_imag,
   output logic [WIDTH-1:0] out1_imag,
   output logic [WIDTH-1:0] out2_imag,
   output logic [WIDTH-1:0] out3_imag,
   output logic [WIDTH-1:0] out4_imag,
   output logic [WIDTH-1:0] out5_imag,
   output logic [WIDTH-1:0] out6_imag,
   output logic [WIDTH-1:0] out7_imag,
   output logic             write,
   output logic             start,
   output logic             frame_done,
   output logic             frame_err,
   output logic [7:0]       frames_issued
);

   typedef enum logic [1:0] {ST_FILL, ST_WRITE, ST_START, ST_DONE} state_t;

   state_t     state_reg, state_next;
   logic [2:0] idx_reg, idx_next;
   logic [3:0] cnt_reg, cnt_next;
   logic       s_ready_reg, s_ready_next;
   logic       write_reg, write_next;
   logic       start_reg, start_next;
   logic       done_reg, done_next;
   logic       err_reg, err_next;
   logic [7:0] frames_reg, frames_next;
   logic       xfer;

   logic [WIDTH-1:0] slot_real [8];
   logic [WIDTH-1:0] slot_imag [8];

   assign xfer = s_valid && s_ready_reg && (state_reg == ST_FILL);

   // State register; every output is registered here from its _next value.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg   <= ST_FILL;
         idx_reg     <= 3'd0;
         cnt_reg     <= 4'd0;
         s_ready_reg <= 1'b0;
         write_reg   <= 1'b0;
         start_reg   <= 1'b0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
         frames_reg  <= 8'd0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         cnt_reg     <= cnt_next;
         s_ready_reg <= s_ready_next;
         write_reg   <= write_next;
         start_reg   <= start_next;
         done_reg    <= done_next;
         err_reg     <= err_next;
         frames_reg  <= frames_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_FILL: begin
            if (xfer) begin
               if (idx_reg == 3'd7) begin
                  idx_next = 3'd0;
                  if (s_last) state_next = ST_WRITE;
               end else if (s_last) begin
                  idx_next = 3'd0;
               end else begin
                  idx_next = idx_reg + 3'd1;
               end
            end
         end
         ST_WRITE: begin
            state_next = ST_START;
            cnt_next   = 4'(START_CYCLES);
         end
         ST_START: begin
            // cnt_reg holds the start cycles still to go, including this one
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg <= 4'd1) state_next = ST_DONE;
         end
         ST_DONE: begin
            state_next = ST_FILL;
         end
         default: begin
            state_next = ST_FILL;
         end
      endcase
   end

   // Output logic: values the outputs take in the coming cycle.
   always_comb begin
      s_ready_next = (state_next == ST_FILL);
      write_next   = (state_next == ST_WRITE);
      start_next   = (state_next == ST_START);
      done_next    = (state_next == ST_DONE);
      // Error when s_last disagrees with the slot position: early s_last,
      // or a missing s_last on the 8th sample.
      err_next     = xfer && ((idx_reg == 3'd7) != s_last);
      frames_next  = (state_next == ST_WRITE) ? frames_reg + 8'd1 : frames_reg;
   end

   // Frame slots: only a FILL transfer addressed to the slot updates it,
   // so contents stay frozen from write through done.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_slot
         logic [WIDTH-1:0] re_reg;
         logic [WIDTH-1:0] im_reg;
         always_ff @(posedge CLK) begin
            if (RST) begin
               re_reg <= '0;
               im_reg <= '0;
            end else if (xfer && (idx_reg == 3'(gi))) begin
               re_reg <= s_real;
               im_reg <= s_imag;
            end
         end
         assign slot_real[gi] = re_reg;
         assign slot_imag[gi] = im_reg;
      end
   endgenerate

   assign s_ready       = s_ready_reg;
   assign write         = write_reg;
   assign start         = start_reg;
   assign frame_done    = done_reg;
   assign frame_err     = err_reg;
   assign frames_issued = frames_reg;

   assign out0_real = slot_real[0];
   assign out1_real = slot_real[1];
   assign out2_real = slot_real[2];
   assign out3_real = slot_real[3];
   assign out4_real = slot_real[4];
   assign out5_real = slot_real[5];
   assign out6_real = slot_real[6];
   assign out7_real = slot_real[7];
   assign out0_imag = slot_imag[0];
   assign out1_imag = slot_imag[1];
   assign out2_imag = slot_imag[2];
   assign out3_imag = slot_imag[3];
   assign out4_imag = slot_imag[4];
   assign out5_imag = slot_imag[5];
   assign out6_imag = slot_imag[6];
   assign out7_imag = slot_imag[7];

endmodule

// File: tb/tb_fft_frame_loader.sv
// Testbench for fft_frame_loader: random and directed sample streams checked
// cycle by cycle against a frame-level reference model.
module tb_fft_frame_loader;

   localparam int W  = 16;
   localparam int SC = 2;

   logic         CLK = 1'b0;
   logic         RST;
   logic         s_valid;
   logic         s_ready;
   logic [W-1:0] s_real;
   logic [W-1:0] s_imag;
   logic         s_last;
   logic [W-1:0] out0_real, out1_real, out2_real, out3_real;
   logic [W-1:0] out4_real, out5_real, out6_real, out7_real;
   logic [W-1:0] out0_imag, out1_imag, out2_imag, out3_imag;
   logic [W-1:0] out4_imag, out5_imag, out6_imag, out7_imag;
   logic         write, start, frame_done, frame_err;
   logic [7:0]   frames_issued;

   always #5 CLK = ~CLK;

   fft_frame_loader #(.WIDTH(W), .START_CYCLES(SC)) dut (
      .CLK(CLK), .RST(RST),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
      .out0_real(out0_real), .out1_real(out1_real), .out2_real(out2_real), .out3_real(out3_real),
      .out4_real(out4_real), .out5_real(out5_real), .out6_real(out6_real), .out7_real(out7_real),
      .out0_imag(out0_imag), .out1_imag(out1_imag), .out2_imag(out2_imag), .out3_imag(out3_imag),
      .out4_imag(out4_imag), .out5_imag(out5_imag), .out6_imag(out6_imag), .out7_imag(out7_imag),
      .write(write), .start(start), .frame_done(frame_done), .frame_err(frame_err),
      .frames_issued(frames_issued)
   );

   logic [W-1:0] o_re [8];
   logic [W-1:0] o_im [8];
   assign o_re[0] = out0_real; assign o_re[1] = out1_real;
   assign o_re[2] = out2_real; assign o_re[3] = out3_real;
   assign o_re[4] = out4_real; assign o_re[5] = out5_real;
   assign o_re[6] = out6_real; assign o_re[7] = out7_real;
   assign o_im[0] = out0_imag; assign o_im[1] = out1_imag;
   assign o_im[2] = out2_imag; assign o_im[3] = out3_imag;
   assign o_im[4] = out4_imag; assign o_im[5] = out5_imag;
   assign o_im[6] = out6_imag; assign o_im[7] = out7_imag;

   typedef struct packed {
      logic [W-1:0] re;
      logic [W-1:0] im;
      logic         last;
   } samp_t;

   samp_t stim_q [$];   // samples upstream still has to deliver
   samp_t cur [$];      // samples of the frame being assembled

   int checks = 0;
   int errors = 0;

   // Reference model: expected values for the cycle currently visible.
   bit           model_valid = 1'b0;
   bit           zchk = 1'b0;     // slots must read zero (post-reset, nothing loaded)
   int           phase = -1;      // -1 while filling, else cycles since last sample accepted
   logic         m_ready, m_write, m_start, m_done, m_err;
   logic [7:0]   m_frames;
   logic [W-1:0] f_re [8];
   logic [W-1:0] f_im [8];
   int           vmode = 0;
   bit           alt = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit pick_valid();
      case (vmode)
         0:       return 1'b1;
         1:       begin alt = ~alt; return alt; end
         default: return ($urandom_range(0, 3) != 0);
      endcase
   endfunction

   task automatic model_update();
      bit    xfer;
      samp_t s;
      xfer = s_valid && m_ready && !RST;
      if (RST) begin
         model_valid = 1'b1;
         zchk        = 1'b1;
         phase       = -1;
         m_frames    = 8'd0;
         m_ready     = 1'b0;
         m_write     = 1'b0;
         m_start     = 1'b0;
         m_done      = 1'b0;
         m_err       = 1'b0;
         cur.delete();
         for (int k = 0; k < 8; k++) begin
            f_re[k] = '0;
            f_im[k] = '0;
         end
      end else begin
         m_err = 1'b0;
         if (phase >= 0) phase = (phase == SC + 2) ? -1 : phase + 1;
         if (phase == 2) m_frames = m_frames + 8'd1;
         if (xfer) begin
            s = stim_q.pop_front();
            cur.push_back(s);
            zchk = 1'b0;
            if (s.last && cur.size() == 8) begin
               for (int k = 0; k < 8; k++) begin
                  f_re[k] = cur[k].re;
                  f_im[k] = cur[k].im;
               end
               cur.delete();
               phase = 1;
               $display("frame handed off: slot0=%h/%h slot7=%h/%h", f_re[0], f_im[0], f_re[7], f_im[7]);
            end else if (s.last || cur.size() == 8) begin
               $display("framing error: frame of %0d samples dropped", cur.size());
               m_err = 1'b1;
               cur.delete();
            end
         end
         m_ready = (phase == -1);
         m_write = (phase == 1);
         m_start = (phase >= 2) && (phase <= SC + 1);
         m_done  = (phase == SC + 2);
      end
   endtask

   // One clock: check the visible cycle, drive inputs, advance on the edge.
   task automatic cycle();
      if (model_valid) begin
         check("s_ready", s_ready, m_ready);
         check("write", write, m_write);
         check("start", start, m_start);
         check("frame_done", frame_done, m_done);
         check("frame_err", frame_err, m_err);
         if (phase != 1) check("frames_issued", frames_issued, m_frames);
         if (phase >= 1 || zchk) begin
            for (int k = 0; k < 8; k++) begin
               check($sformatf("slot%0d_real", k), o_re[k], f_re[k]);
               check($sformatf("slot%0d_imag", k), o_im[k], f_im[k]);
            end
         end
      end
      if (stim_q.size() > 0 && pick_valid()) begin
         s_valid = 1'b1;
         s_real  = stim_q[0].re;
         s_imag  = stim_q[0].im;
         s_last  = stim_q[0].last;
      end else begin
         s_valid = 1'b0;
         s_real  = W'($urandom);
         s_imag  = W'($urandom);
         s_last  = 1'($urandom);
      end
      @(posedge CLK);
      model_update();
      @(negedge CLK);
   endtask

   task automatic push_frame(input int n, input int last_at);
      samp_t s;
      for (int i = 1; i <= n; i++) begin
         s.re   = W'($urandom);
         s.im   = W'($urandom);
         s.last = (i == last_at);
         stim_q.push_back(s);
      end
   endtask

   task automatic push_dir();
      samp_t s;
      for (int k = 0; k < 8; k++) begin
         s.re   = W'(k + 1);
         s.im   = W'(-(k + 1));
         s.last = (k == 7);
         stim_q.push_back(s);
      end
   endtask

   task automatic run_until_idle(input int budget);
      int n = 0;
      while ((stim_q.size() > 0 || phase != -1) && n < budget) begin
         cycle();
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL budget observed=%0d cycles expected=idle before %0d", n, budget);
      end
      cycle();
   endtask

   initial begin
      RST     = 1'b1;
      s_valid = 1'b0;
      s_real  = '0;
      s_imag  = '0;
      s_last  = 1'b0;
      @(negedge CLK);
      cycle();
      cycle();
      RST = 1'b0;

      // Directed frame, back to back
      push_dir();
      vmode = 0;
      run_until_idle(100);
      check("dir_out3_real", out3_real, 32'h4);
      check("dir_out3_imag", out3_imag, 32'hFFFC);
      check("dir_frames", frames_issued, 32'd1);

      // Same frame with alternate-cycle stalls
      push_dir();
      vmode = 1;
      run_until_idle(100);
      check("stall_out3_real", out3_real, 32'h4);
      check("stall_out3_imag", out3_imag, 32'hFFFC);
      check("stall_frames", frames_issued, 32'd2);

      // Early s_last, then a clean frame
      push_frame(5, 5);
      push_frame(8, 8);
      vmode = 2;
      run_until_idle(200);

      // Missing s_last, then a clean frame
      push_frame(8, 0);
      vmode = 0;
      run_until_idle(200);
      push_frame(8, 8);
      run_until_idle(200);

      // Reset during START
      push_frame(8, 8);
      vmode = 0;
      for (int n = 0; n < 50 && phase != 2; n++) cycle();
      check("reached_start", start, 32'd1);
      RST = 1'b1;
      cycle();
      RST = 1'b0;
      check("rst_start", start, 32'd0);
      check("rst_frames", frames_issued, 32'd0);
      check("rst_out0_real", out0_real, 32'd0);
      check("rst_out7_imag", out7_imag, 32'd0);
      cycle();
      check("rst_ready", s_ready, 32'd1);
      stim_q.delete();
      run_until_idle(100);

      // Random mix of clean and malformed frames
      for (int f = 0; f < 20; f++) begin
         int r;
         int n;
         r = $urandom_range(0, 3);
         if (r == 0) begin
            n = $urandom_range(1, 7);
            push_frame(n, n);
         end else if (r == 1) begin
            push_frame(8, 0);
         end else begin
            push_frame(8, 8);
         end
         vmode = $urandom_range(0, 2);
         run_until_idle(300);
      end

      // 256 clean frames from reset: counter wraps back to 0
      RST = 1'b1;
      cycle();
      RST = 1'b0;
      for (int f = 0; f < 256; f++) push_frame(8, 8);
      vmode = 2;
      run_until_idle(20000);
      check("wrap_frames", frames_issued, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
